// File: rtl/pwm_wave_multi.sv
// Multi-channel PWM waveform generator: shared PWM counter and phase, per-channel offset/mode.
// Optional macro PWM_WAVE_AMPLITUDE_EN adds a per-channel 4-bit amplitude scale (cfg_amp).
module pwm_wave_multi #(
  parameter  int CHANNELS = 3,
  parameter  int DIV_W    = 12,
  parameter  int PWM_W    = 8,
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [DIV_W-1:0]    divider,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_chan,
  input  logic [7:0]          cfg_phase,
  input  logic [1:0]          cfg_mode,
`ifdef PWM_WAVE_AMPLITUDE_EN
  input  logic [3:0]          cfg_amp,
`endif
  output logic [CHANNELS-1:0] pwm,
  output logic                period_end
);

  localparam logic [PWM_W-1:0] CNT_MAX = '1;

  logic [PWM_W-1:0] pwm_cnt;
  logic [DIV_W-1:0] div_cnt;
  logic [7:0]       phase;
  logic [PWM_W-1:0] duty      [CHANNELS];
  logic [PWM_W-1:0] next_duty [CHANNELS];
  logic [7:0]       offset    [CHANNELS];
  logic [1:0]       mode      [CHANNELS];
  logic             pending;
  logic [CH_W-1:0]  lat_chan;
  logic [7:0]       lat_phase;
  logic [1:0]       lat_mode;
  logic             accept;
  logic             apply;
`ifdef PWM_WAVE_AMPLITUDE_EN
  logic [3:0]       amp [CHANNELS];
  logic [3:0]       lat_amp;
`endif

  // Quarter-wave table q(k) = round(127.5 + 127.5*sin(2*pi*k/256)), k = 0..64
  function automatic logic [7:0] sine_q(input logic [6:0] k);
    logic [7:0] q;
    case (k)
      7'd0:  q = 8'd128; 7'd1:  q = 8'd131; 7'd2:  q = 8'd134; 7'd3:  q = 8'd137;
      7'd4:  q = 8'd140; 7'd5:  q = 8'd143; 7'd6:  q = 8'd146; 7'd7:  q = 8'd149;
      7'd8:  q = 8'd152; 7'd9:  q = 8'd155; 7'd10: q = 8'd158; 7'd11: q = 8'd162;
      7'd12: q = 8'd165; 7'd13: q = 8'd167; 7'd14: q = 8'd170; 7'd15: q = 8'd173;
      7'd16: q = 8'd176; 7'd17: q = 8'd179; 7'd18: q = 8'd182; 7'd19: q = 8'd185;
      7'd20: q = 8'd188; 7'd21: q = 8'd190; 7'd22: q = 8'd193; 7'd23: q = 8'd196;
      7'd24: q = 8'd198; 7'd25: q = 8'd201; 7'd26: q = 8'd203; 7'd27: q = 8'd206;
      7'd28: q = 8'd208; 7'd29: q = 8'd211; 7'd30: q = 8'd213; 7'd31: q = 8'd215;
      7'd32: q = 8'd218; 7'd33: q = 8'd220; 7'd34: q = 8'd222; 7'd35: q = 8'd224;
      7'd36: q = 8'd226; 7'd37: q = 8'd228; 7'd38: q = 8'd230; 7'd39: q = 8'd232;
      7'd40: q = 8'd234; 7'd41: q = 8'd235; 7'd42: q = 8'd237; 7'd43: q = 8'd238;
      7'd44: q = 8'd240; 7'd45: q = 8'd241; 7'd46: q = 8'd243; 7'd47: q = 8'd244;
      7'd48: q = 8'd245; 7'd49: q = 8'd246; 7'd50: q = 8'd248; 7'd51: q = 8'd249;
      7'd52: q = 8'd250; 7'd53: q = 8'd250; 7'd54: q = 8'd251; 7'd55: q = 8'd252;
      7'd56: q = 8'd253; 7'd57: q = 8'd253; 7'd58: q = 8'd254; 7'd59: q = 8'd254;
      7'd60: q = 8'd254; 7'd61: q = 8'd255; 7'd62: q = 8'd255; 7'd63: q = 8'd255;
      7'd64: q = 8'd255;
      default: q = 8'd255;
    endcase
    return q;
  endfunction

  // Upper half of the sine is the mirrored, inverted lower half
  function automatic logic [7:0] wave_sample(input logic [7:0] i, input logic [1:0] m);
    logic [6:0] j;
    logic [7:0] base;
    logic [7:0] s;
    j    = i[6:0];
    base = 8'd0;
    case (m)
      2'b00: begin
        if (j < 7'd64) begin
          base = sine_q(j);
        end else begin
          base = sine_q(7'(8'd128 - {1'b0, j}));
        end
        if (i[7]) begin
          s = 8'd255 - base;
        end else begin
          s = base;
        end
      end
      2'b01: begin
        if (i[7]) begin
          s = ~{j, 1'b0};
        end else begin
          s = {j, 1'b0};
        end
      end
      2'b10:   s = i;
      2'b11:   s = 8'd0;
      default: s = 8'd0;
    endcase
    return s;
  endfunction

  function automatic logic [7:0] offset_init(input int c);
    return 8'((c * 256) / CHANNELS);
  endfunction

  assign period_end = enable && (pwm_cnt == CNT_MAX);
  assign accept     = cfg_valid && cfg_ready;
  assign apply      = pending && period_end;

  // Next duty per channel from the pre-update phase and configuration
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      logic [7:0]  idx;
      logic [7:0]  s;
      logic [7:0]  scaled;
`ifdef PWM_WAVE_AMPLITUDE_EN
      logic [11:0] prod;
`endif
      next_duty[c] = '0;
      idx          = phase + offset[c];
      s            = wave_sample(idx, mode[c]);
`ifdef PWM_WAVE_AMPLITUDE_EN
      prod         = {4'd0, s} * {7'd0, {1'b0, amp[c]} + 5'd1};
      scaled       = 8'(prod >> 4);
`else
      scaled       = s;
`endif
      next_duty[c] = PWM_W'(scaled) << (PWM_W - 8);
    end
  end

  // PWM counter, divider counter and shared phase
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
      div_cnt <= '0;
      phase   <= 8'd0;
    end else if (enable) begin
      pwm_cnt <= pwm_cnt + PWM_W'(1);
      if (period_end) begin
        // >= so a divider lowered below the running count wraps immediately
        if (div_cnt >= divider) begin
          div_cnt <= '0;
          phase   <= phase + 8'd1;
        end else begin
          div_cnt <= div_cnt + DIV_W'(1);
        end
      end
    end
  end

  // Config handshake: latch on accept, commit on the next period boundary
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending   <= 1'b0;
      cfg_ready <= 1'b0;
      lat_chan  <= '0;
      lat_phase <= 8'd0;
      lat_mode  <= 2'b00;
`ifdef PWM_WAVE_AMPLITUDE_EN
      lat_amp   <= 4'd15;
`endif
    end else if (accept) begin
      pending   <= 1'b1;
      cfg_ready <= 1'b0;
      lat_chan  <= cfg_chan;
      lat_phase <= cfg_phase;
      lat_mode  <= cfg_mode;
`ifdef PWM_WAVE_AMPLITUDE_EN
      lat_amp   <= cfg_amp;
`endif
    end else if (apply) begin
      pending   <= 1'b0;
      cfg_ready <= 1'b1;
    end else begin
      cfg_ready <= !pending;
    end
  end

  // Per-channel config registers; out-of-range channel writes match nothing
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < CHANNELS; c++) begin
        offset[c] <= offset_init(c);
        mode[c]   <= 2'b00;
`ifdef PWM_WAVE_AMPLITUDE_EN
        amp[c]    <= 4'd15;
`endif
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (apply && (int'(lat_chan) == c)) begin
          offset[c] <= lat_phase;
          mode[c]   <= lat_mode;
`ifdef PWM_WAVE_AMPLITUDE_EN
          amp[c]    <= lat_amp;
`endif
        end
      end
    end
  end

  // Duty registers reload at the period boundary
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < CHANNELS; c++) begin
        duty[c] <= '0;
      end
    end else if (period_end) begin
      for (int c = 0; c < CHANNELS; c++) begin
        duty[c] <= next_duty[c];
      end
    end
  end

  // Registered PWM comparators
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwm <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        pwm[c] <= enable && (pwm_cnt < duty[c]);
      end
    end
  end

endmodule
